// File: rtl/jk_pkg.sv
// Shared op codes, FSM encoding and default bank width for the JK excitation controller.
package jk_pkg;

  localparam int JK_WIDTH_DEF = 4;

  typedef enum logic [2:0] {
    OP_HOLD   = 3'd0,
    OP_LOAD   = 3'd1,
    OP_INC    = 3'd2,
    OP_DEC    = 3'd3,
    OP_CLR    = 3'd4,
    OP_TOGGLE = 3'd5,
    OP_SHL    = 3'd6,
    OP_RSVD   = 3'd7
  } jk_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } jk_state_e;

endpackage

// File: rtl/jk_excite.sv
// One JK excitation cell: chooses j/k so a JK flip-flop currently at q lands on t.
module jk_excite (
  input  logic q,
  input  logic t,
  input  logic en,
  input  logic toggle,
  output logic j,
  output logic k
);

  always_comb begin
    j = 1'b0;
    k = 1'b0;
    if (en) begin
      if (toggle) begin
        j = 1'b1;
        k = 1'b1;
      end else begin
        j = ~q & t;
        k = q & ~t;
      end
    end
  end

endmodule

// File: rtl/jk_excite_ctrl.sv
// Command sequencer that steps a downstream JK flip-flop bank toward an op-dependent
// target for cmd_count+1 cycles, then pulses done.
module jk_excite_ctrl
  import jk_pkg::*;
#(
  parameter int WIDTH = JK_WIDTH_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [3:0]       cmd_count,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  output logic             busy,
  output logic             done
);

  // state | meaning
  // IDLE  | ready for a command, JK bank held
  // RUN   | drive j/k toward the target every cycle, count steps down
  // DONE  | one-cycle completion pulse, JK bank held

  jk_state_e        state_q;
  jk_state_e        state_d;
  jk_op_e           op_q;
  logic [WIDTH-1:0] data_q;
  logic [3:0]       step_cnt_q;
  logic             run_en;
  logic             toggle_en;
  logic [WIDTH-1:0] target;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      step_cnt_q <= 4'd0;
      op_q       <= OP_HOLD;
      data_q     <= '0;
    end else if (state_q == ST_IDLE && cmd_valid) begin
      step_cnt_q <= cmd_count;
      op_q       <= jk_op_e'(cmd_op);
      data_q     <= cmd_data;
    end else if (state_q == ST_RUN && step_cnt_q != 4'd0) begin
      step_cnt_q <= step_cnt_q - 4'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (cmd_valid) state_d = ST_RUN;
      ST_RUN:  if (step_cnt_q == 4'd0) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // cmd_ready is masked by reset because the state register already reads IDLE while reset is held.
  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    run_en    = 1'b0;
    case (state_q)
      ST_IDLE: cmd_ready = ~reset;
      ST_RUN: begin
        busy   = 1'b1;
        run_en = 1'b1;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign toggle_en = (op_q == OP_TOGGLE);

  always_comb begin
    target = q_in;
    case (op_q)
      OP_LOAD: target = data_q;
      OP_INC:  target = q_in + WIDTH'(1);
      OP_DEC:  target = q_in - WIDTH'(1);
      OP_CLR:  target = '0;
      OP_TOGGLE: target = ~q_in;
      OP_SHL: begin
        target    = q_in << 1;
        target[0] = data_q[0];
      end
      default: target = q_in;
    endcase
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_excite u_cell (
      .q      (q_in[i]),
      .t      (target[i]),
      .en     (run_en),
      .toggle (toggle_en),
      .j      (j_out[i]),
      .k      (k_out[i])
    );
  end

endmodule

// File: tb/tb_jk_excite_ctrl.sv
// Bench for jk_excite_ctrl: a JK bank model closes the loop on j/k; table vectors,
// random commands and hand sequences for busy rejection and reset mid-run.
module tb_jk_excite_ctrl;
  import jk_pkg::*;

  localparam int W = 4;

  logic         clock = 1'b0;
  logic         reset;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [2:0]   cmd_op;
  logic [W-1:0] cmd_data;
  logic [3:0]   cmd_count;
  logic [W-1:0] j_out;
  logic [W-1:0] k_out;
  logic         busy;
  logic         done;

  logic [W-1:0] bank_q;
  logic         bank_load;
  logic [W-1:0] bank_val;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clock = ~clock;

  jk_excite_ctrl #(.WIDTH(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_count (cmd_count),
    .q_in      (bank_q),
    .j_out     (j_out),
    .k_out     (k_out),
    .busy      (busy),
    .done      (done)
  );

  // Downstream JK flip-flop bank, with a preload port for test setup.
  always @(posedge clock) begin
    if (bank_load) bank_q <= bank_val;
    else begin
      for (int i = 0; i < W; i++) begin
        case ({j_out[i], k_out[i]})
          2'b10: bank_q[i] <= 1'b1;
          2'b01: bank_q[i] <= 1'b0;
          2'b11: bank_q[i] <= ~bank_q[i];
          default: ;
        endcase
      end
    end
  end

  function automatic logic [W-1:0] ref_target(input logic [2:0] op, input logic [W-1:0] d,
                                              input logic [W-1:0] q);
    int m  = 1 << W;
    int qi = int'(q);
    case (op)
      3'd1: return d;
      3'd2: return W'((qi + 1) % m);
      3'd3: return W'((qi + m - 1) % m);
      3'd4: return '0;
      3'd5: return ~q;
      3'd6: return W'(((qi * 2) % m) + int'(d[0]));
      default: return q;
    endcase
  endfunction

  function automatic void ref_jk(input logic [2:0] op, input logic [W-1:0] q,
                                 input logic [W-1:0] t,
                                 output logic [W-1:0] j, output logic [W-1:0] k);
    for (int i = 0; i < W; i++) begin
      if (op == 3'd5) {j[i], k[i]} = 2'b11;
      else begin
        case ({q[i], t[i]})
          2'b01:   {j[i], k[i]} = 2'b10;
          2'b10:   {j[i], k[i]} = 2'b01;
          default: {j[i], k[i]} = 2'b00;
        endcase
      end
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [W-1:0] q0);
    @(negedge clock);
    bank_load = 1'b1;
    bank_val  = q0;
    @(negedge clock);
    bank_load = 1'b0;
  endtask

  // Issues one command from IDLE and follows it through RUN, DONE and back to IDLE.
  task automatic run_cmd(input string tag, input logic [2:0] op, input logic [W-1:0] d,
                         input logic [3:0] cnt, input logic [W-1:0] q0,
                         output logic [W-1:0] q_end, output logic [W-1:0] j0,
                         output logic [W-1:0] k0);
    logic [W-1:0] qm, t, je, ke;
    preload(q0);
    check({tag, " ready"}, cmd_ready, 1'b1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    cmd_count = cnt;
    qm = q0;
    for (int s = 0; s <= int'(cnt); s++) begin
      @(negedge clock);
      if (s == 0) begin
        cmd_valid = 1'b0;
        j0 = j_out;
        k0 = k_out;
      end
      t = ref_target(op, d, qm);
      ref_jk(op, qm, t, je, ke);
      check({tag, " busy"}, busy, 1'b1);
      check({tag, " j"}, j_out, je);
      check({tag, " k"}, k_out, ke);
      qm = t;
    end
    @(negedge clock);
    check({tag, " done"}, done, 1'b1);
    check({tag, " done jk"}, {j_out, k_out}, '0);
    check({tag, " done ready"}, cmd_ready, 1'b0);
    @(negedge clock);
    check({tag, " done drop"}, done, 1'b0);
    check({tag, " idle ready"}, cmd_ready, 1'b1);
    check({tag, " q model"}, bank_q, qm);
    q_end = bank_q;
  endtask

  typedef struct {
    string        name;
    logic [2:0]   op;
    logic [W-1:0] data;
    logic [3:0]   cnt;
    logic [W-1:0] q0;
    logic [W-1:0] q_final;
    logic [W-1:0] j0;
    logic [W-1:0] k0;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [W-1:0] qe, jf, kf, qm;
    logic [2:0]   rop;
    logic [W-1:0] rd, rq;
    logic [3:0]   rc;

    vecs[0] = '{"load",     3'd1, 4'b1010, 4'd0, 4'b0000, 4'b1010, 4'b1010, 4'b0000};
    vecs[1] = '{"inc_wrap", 3'd2, 4'b0000, 4'd2, 4'b1110, 4'b0001, 4'b0001, 4'b0000};
    vecs[2] = '{"toggle",   3'd5, 4'b0000, 4'd1, 4'b0101, 4'b0101, 4'b1111, 4'b1111};
    vecs[3] = '{"shl",      3'd6, 4'b0001, 4'd1, 4'b0011, 4'b1111, 4'b0100, 4'b0000};
    vecs[4] = '{"dec_wrap", 3'd3, 4'b0000, 4'd0, 4'b0000, 4'b1111, 4'b1111, 4'b0000};
    vecs[5] = '{"clr",      3'd4, 4'b1111, 4'd3, 4'b1011, 4'b0000, 4'b0000, 4'b1011};
    vecs[6] = '{"hold",     3'd0, 4'b1111, 4'd1, 4'b0110, 4'b0110, 4'b0000, 4'b0000};
    vecs[7] = '{"rsvd",     3'd7, 4'b1111, 4'd0, 4'b1001, 4'b1001, 4'b0000, 4'b0000};
    vecs[8] = '{"load2",    3'd1, 4'b0101, 4'd0, 4'b1100, 4'b0101, 4'b0001, 4'b1000};
    vecs[9] = '{"inc16",    3'd2, 4'b0000, 4'd15, 4'b0011, 4'b0011, 4'b0100, 4'b0011};

    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_data  = '0;
    cmd_count = 4'd0;
    bank_load = 1'b0;
    bank_val  = '0;
    bank_q    = '0;

    #1;
    check("rst ready", cmd_ready, 1'b0);
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    check("rst jk", {j_out, k_out}, '0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("post rst ready", cmd_ready, 1'b1);
    check("post rst busy", busy, 1'b0);

    foreach (vecs[i]) begin
      run_cmd(vecs[i].name, vecs[i].op, vecs[i].data, vecs[i].cnt, vecs[i].q0, qe, jf, kf);
      check({vecs[i].name, " q final"}, qe, vecs[i].q_final);
      check({vecs[i].name, " j first"}, jf, vecs[i].j0);
      check({vecs[i].name, " k first"}, kf, vecs[i].k0);
    end

    // Busy rejection: cmd_valid stays high with a different op through the first command.
    preload(4'b0000);
    cmd_valid = 1'b1;
    cmd_op    = 3'd1;
    cmd_data  = 4'b0011;
    cmd_count = 4'd1;
    @(negedge clock);
    cmd_op    = 3'd2;
    cmd_data  = 4'b0000;
    cmd_count = 4'd0;
    check("rej run1 ready", cmd_ready, 1'b0);
    check("rej run1 j", j_out, 4'b0011);
    check("rej run1 k", k_out, 4'b0000);
    @(negedge clock);
    check("rej run2 ready", cmd_ready, 1'b0);
    check("rej run2 busy", busy, 1'b1);
    check("rej run2 jk", {j_out, k_out}, '0);
    @(negedge clock);
    check("rej done", done, 1'b1);
    check("rej done ready", cmd_ready, 1'b0);
    @(negedge clock);
    check("rej idle ready", cmd_ready, 1'b1);
    check("rej idle q", bank_q, 4'b0011);
    @(negedge clock);
    cmd_valid = 1'b0;
    check("rej second busy", busy, 1'b1);
    check("rej second j", j_out, 4'b0100);
    check("rej second k", k_out, 4'b0011);
    @(negedge clock);
    check("rej second done", done, 1'b1);
    @(negedge clock);
    check("rej second q", bank_q, 4'b0100);
    check("rej second idle", cmd_ready, 1'b1);

    // Reset in the middle of a long DEC.
    preload(4'b0000);
    cmd_valid = 1'b1;
    cmd_op    = 3'd3;
    cmd_data  = '0;
    cmd_count = 4'd15;
    qm = 4'b0000;
    for (int s = 0; s < 5; s++) begin
      logic [W-1:0] t, je, ke;
      @(negedge clock);
      cmd_valid = 1'b0;
      t = ref_target(3'd3, 4'b0000, qm);
      ref_jk(3'd3, qm, t, je, ke);
      check("mid dec j", j_out, je);
      check("mid dec k", k_out, ke);
      qm = t;
    end
    #2 reset = 1'b1;
    #1;
    check("mid rst jk", {j_out, k_out}, '0);
    check("mid rst busy", busy, 1'b0);
    check("mid rst ready", cmd_ready, 1'b0);
    check("mid rst done", done, 1'b0);
    @(negedge clock);
    check("mid rst hold done", done, 1'b0);
    reset = 1'b0;
    @(negedge clock);
    check("mid rel ready", cmd_ready, 1'b1);
    check("mid rel done", done, 1'b0);
    check("mid rel busy", busy, 1'b0);
    @(negedge clock);
    check("mid rel done2", done, 1'b0);

    // Random commands against the reference model.
    for (int n = 0; n < 30; n++) begin
      rop = 3'($urandom_range(0, 7));
      rd  = W'($urandom);
      rc  = 4'($urandom_range(0, 7));
      rq  = W'($urandom);
      qm  = rq;
      for (int s = 0; s <= int'(rc); s++) qm = ref_target(rop, rd, qm);
      run_cmd("rand", rop, rd, rc, rq, qe, jf, kf);
      check("rand q final", qe, qm);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
